// File: rtl/uart_lite_pkg.sv
// AXI UART Lite register map, AXI encodings and
// state sets shared by the echo initiator.
package uart_lite_pkg;

  localparam logic [7:0] RX_FIFO = 8'h0;
  localparam logic [7:0] TX_FIFO = 8'h4;
  localparam logic [7:0] STAT    = 8'h8;
  localparam logic [7:0] CTRL    = 8'hC;

  localparam int RX_VALID = 0;
  localparam int TX_FULL  = 3;

  localparam logic [31:0] FIFO_RST = 32'h3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    INIT_W,
    INIT_B,
    POLL_WAIT,
    STAT_AR,
    STAT_R,
    RX_AR,
    RX_R,
    TXS_AR,
    TXS_R,
    TX_W,
    TX_B,
    ERR
  } echo_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_W,
    P_B,
    P_AR,
    P_R
  } port_state_t;

endpackage

// File: rtl/axi_lite_master_port.sv
// Single-transaction AXI4-Lite initiator port;
// owns all valid/ready sequencing.
module axi_lite_master_port
  import uart_lite_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic [1:0]        resp,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  port_state_t       ps, ps_nx;
  logic              aw_ok, w_ok;
  logic              aw_hs, w_hs;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;

  always_ff @(posedge clk) begin
    if (rst) ps <= P_IDLE;
    else     ps <= ps_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (ps == P_IDLE && start) begin
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      addr_q  <= addr;
      wdata_q <= wdata;
    end else begin
      aw_ok <= aw_ok | aw_hs;
      w_ok  <= w_ok | w_hs;
    end
  end

  always_comb begin
    ps_nx = ps;
    unique case (ps)
      P_IDLE: if (start) ps_nx = wr ? P_W : P_AR;
      P_W: begin
        if ((aw_ok | aw_hs) && (w_ok | w_hs))
          ps_nx = P_B;
      end
      P_B:  if (m_bvalid) ps_nx = P_IDLE;
      P_AR: if (m_arready) ps_nx = P_R;
      P_R:  if (m_rvalid) ps_nx = P_IDLE;
      default: ps_nx = P_IDLE;
    endcase
  end

  // Each write channel drops on its own once its handshake is seen.
  always_comb begin
    m_awvalid = (ps == P_W) && !aw_ok;
    m_wvalid  = (ps == P_W) && !w_ok;
    m_bready  = (ps == P_B);
    m_arvalid = (ps == P_AR);
    m_rready  = (ps == P_R);
    done = ((ps == P_B) && m_bvalid)
        || ((ps == P_R) && m_rvalid);
    resp = (ps == P_B) ? m_bresp : m_rresp;
  end

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = 4'b0001;
  assign rdata    = m_rdata;

endmodule

// File: rtl/axi_uart_echo_master.sv
// Hardware echo: polls the UART Lite status and
// writes every received byte back to the TX FIFO.
module axi_uart_echo_master
  import uart_lite_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int POLL_GAP = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [CNT_W-1:0]  echo_count,
  output logic [7:0]        last_byte,
  output logic              busy,
  output logic              err
);

  localparam int GAP_W = $clog2(POLL_GAP + 2);

  echo_state_t       st, st_nx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        byte_q;
  logic              start, wr, done, bad;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, rdata;
  logic [1:0]        resp;
  logic              unused_rdata;

  assign bad = done && (resp != OKAY);
  assign unused_rdata = ^rdata[31:8];

  axi_lite_master_port #(.ADDR_W(ADDR_W)) u_port (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .resp      (resp),
    .rdata     (rdata),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:   if (enable) st_nx = INIT_W;
      INIT_W: st_nx = INIT_B;
      INIT_B: if (done) st_nx = bad ? ERR : POLL_WAIT;
      POLL_WAIT: begin
        if (!enable)
          st_nx = IDLE;
        else if (gap_cnt == GAP_W'(POLL_GAP))
          st_nx = STAT_AR;
      end
      STAT_AR: st_nx = STAT_R;
      STAT_R: begin
        if (done)
          st_nx = bad ? ERR
                : rdata[RX_VALID] ? RX_AR : POLL_WAIT;
      end
      RX_AR: st_nx = RX_R;
      RX_R:  if (done) st_nx = bad ? ERR : TXS_AR;
      TXS_AR: st_nx = TXS_R;
      TXS_R: begin
        if (done)
          st_nx = bad ? ERR
                : rdata[TX_FULL] ? TXS_AR : TX_W;
      end
      TX_W: st_nx = TX_B;
      TX_B: if (done) st_nx = bad ? ERR : POLL_WAIT;
      ERR:  st_nx = ERR;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    unique case (st)
      INIT_W: begin
        start = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_W'(CTRL);
        wdata = FIFO_RST;
      end
      STAT_AR, TXS_AR: begin
        start = 1'b1;
        addr  = ADDR_W'(STAT);
      end
      RX_AR: begin
        start = 1'b1;
        addr  = ADDR_W'(RX_FIFO);
      end
      TX_W: begin
        start = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_W'(TX_FIFO);
        wdata = {24'b0, byte_q};
      end
      default: begin
      end
    endcase
    busy = (st != IDLE) && (st != ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt    <= '0;
      byte_q     <= '0;
      echo_count <= '0;
      last_byte  <= '0;
      err        <= 1'b0;
    end else begin
      gap_cnt <= (st == POLL_WAIT) ? gap_cnt + 1'b1 : '0;
      if (st == RX_R && done && !bad)
        byte_q <= rdata[7:0];
      if (st == TX_B && done && !bad) begin
        echo_count <= echo_count + 1'b1;
        last_byte  <= byte_q;
      end
      if (bad)
        err <= 1'b1;
    end
  end

endmodule

// File: doc/axi_uart_echo_master.md
Name: axi_uart_echo_master

Overview:
- AXI4-Lite initiator that drives the AXI UART Lite register map (RX FIFO 0x0, TX FIFO 0x4, STAT 0x8, CTRL 0xC) from the fabric side.
- After reset it clears both FIFOs, then polls status. Each received byte is read and written back to the TX FIFO, giving a hardware echo.
- Sits beside the UART IP inside the block-design wrapper, in place of a processor.

Parameters:
- ADDR_W, 4, AXI address width in bits.
- POLL_GAP, 16, idle cycles between consecutive STAT polls; 0 means back-to-back polls.
- CNT_W, 16, width of echo_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits leaving IDLE; sampled only in IDLE and POLL_WAIT.
- m_awaddr  out  ADDR_W  write address.
- m_awvalid  out  1  write address valid.
- m_awready  in  1  write address ready.
- m_wdata  out  32  write data.
- m_wstrb  out  4  write strobes; always 4'b0001.
- m_wvalid  out  1  write data valid.
- m_wready  in  1  write data ready.
- m_bresp  in  2  write response.
- m_bvalid  in  1  write response valid.
- m_bready  out  1  write response ready.
- m_araddr  out  ADDR_W  read address.
- m_arvalid  out  1  read address valid.
- m_arready  in  1  read address ready.
- m_rdata  in  32  read data.
- m_rresp  in  2  read response.
- m_rvalid  in  1  read data valid.
- m_rready  out  1  read data ready.
- echo_count  out  CNT_W  bytes successfully echoed; wraps modulo 2^CNT_W.
- last_byte  out  8  most recently echoed byte.
- busy  out  1  high whenever the state is not IDLE or ERR.
- err  out  1  sticky; set on any non-OKAY bresp or rresp.

Behaviour:
- Reset: clk is the only clock. rst is synchronous and active-high. Reset forces state IDLE and drives every valid/ready output, echo_count, last_byte, busy and err to 0. Reset mid-transaction abandons the transfer without completing it.
- Addresses: each transaction presents its address register value.
- Write channel:
  - awvalid and wvalid assert in the same cycle.
  - Each drops independently the cycle after its own ready is sampled high.
  - bready asserts once both AW and W have completed, and stays high until bvalid.
  - Addr and data are held stable while valid is high.
- Read channel:
  - arvalid is held until arready.
  - rready asserts the cycle after AR completes and stays high until rvalid.
- No outstanding-transaction overlap: one transaction at a time.
- States and transitions:
  - IDLE -> INIT_W when enable.
  - INIT_W: write CTRL = 0x3 (reset TX and RX FIFOs) -> INIT_B.
  - INIT_B -> POLL_WAIT on bvalid.
  - POLL_WAIT: count POLL_GAP cycles -> STAT_AR. If enable is low, go to IDLE instead.
  - STAT_AR -> STAT_R.
  - STAT_R on rvalid: if rdata[0] (RX valid) -> RX_AR, else -> POLL_WAIT.
  - RX_AR -> RX_R.
  - RX_R on rvalid: latch rdata[7:0] into a byte register -> TXS_AR.
  - TXS_AR -> TXS_R.
  - TXS_R on rvalid: if rdata[3] (TX full) -> TXS_AR (re-poll, no gap), else -> TX_W.
  - TX_W: write TX FIFO with wdata = {24'b0, byte} -> TX_B.
  - TX_B on bvalid with bresp == OKAY: echo_count += 1, last_byte <= byte -> POLL_WAIT.
- Error:
  - Any bresp or rresp != 2'b00 when the handshake completes sets err and moves to ERR.
  - ERR is terminal until rst. No AXI activity occurs in ERR.
  - echo_count is not incremented for the failing write.
- Simultaneous events:
  - awready and wready in the same cycle complete both channels that cycle.
  - bvalid is accepted only after both AW and W are done; a bvalid seen earlier is ignored.
- Counter wrap: echo_count at all-ones plus 1 gives 0. No flag is raised.
- Dropping enable mid-echo is ignored until the next POLL_WAIT.

Decomposition:
- Shared package uart_lite_pkg holds:
  - Register offsets RX_FIFO=0x0, TX_FIFO=0x4, STAT=0x8, CTRL=0xC.
  - STAT bit indices RX_VALID=0, TX_FULL=3.
  - CTRL value FIFO_RST=0x3.
  - AXI response encodings OKAY=2'b00, SLVERR=2'b10.
  - The state enum.
- One natural sub-module is axi_lite_master_port. It performs single read/write transactions through a start/done/resp interface and owns all valid/ready sequencing. The FSM in the top level sequences it.

Test Plan:
- Slave model with 0-cycle ready, rst pulse, enable=1 -> first transaction is a write of 0x3 to 0xC with wstrb=0001. STAT reads at 0x8 then repeat every POLL_GAP+~3 cycles while STAT returns 0x00.
- STAT returns 0x01, RX returns 0x41, next STAT returns 0x04 -> write 0x41 to 0x4. echo_count=1, last_byte=0x41.
- TX-full check returns 0x08 three times then 0x04 -> exactly 4 reads of 0x8 before the TX write, with no gap delay between them.
- Slave delays wready 3 cycles after awready -> awvalid drops after 1 cycle and wvalid holds 4 cycles. bready does not rise until W completes.
- RX read returns rresp=2'b10 -> err=1 and busy=0, with no further valid asserted over 100 cycles. Then rst -> err=0 and echo_count=0.
- CNT_W=4, 17 echoed bytes -> echo_count=1. Reset asserted during TX_B -> all outputs 0 the next cycle.
